// File: rtl/draw_obstacle.sv
// Obstacle column overlay for the video pipeline. Positions and endgame state are latched
// once per frame on the vsync rising edge, and every pixel passes through two register stages.
module draw_obstacle #(
  parameter int          OBST_W       = 40,
  parameter logic [11:0] OBST_COLOR   = 12'h0_A_0,
  parameter logic [11:0] END_COLOR    = 12'hF_0_0,
  parameter int          BLINK_FRAMES = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        hblnk_in,
  input  logic        vsync_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [11:0] obstacle_xpos_1,
  input  logic [11:0] obstacle_ypos_1,
  input  logic [11:0] obstacle_ypos_2,
  input  logic        endgame,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        hblnk_out,
  output logic        vsync_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);

  localparam logic [7:0]  BLINK_LAST = 8'(BLINK_FRAMES - 1);
  localparam logic [12:0] OBST_W13   = 13'(OBST_W);

  typedef enum logic {
    MODE_PLAY,
    MODE_END
  } mode_t;

  mode_t       mode_q, mode_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic        blink_q, blink_d;

  logic        vsync_prev;
  logic        vsync_rise;
  logic [11:0] shadow_x, shadow_y1, shadow_y2;
  logic        shadow_valid;

  logic [12:0] h13, v13, x_lo, x_hi;
  logic        in_x, in_up, in_low, hit;
  logic [11:0] obst_color;
  logic [11:0] pix_color;

  logic [10:0] hcount_s1, vcount_s1;
  logic        hsync_s1, hblnk_s1, vsync_s1, vblnk_s1;
  logic [11:0] rgb_s1;

  assign vsync_rise = vsync_in & ~vsync_prev;

  // Frame latch: the shadow copy is what gets drawn, so the column never tears mid-frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_prev   <= 1'b0;
      shadow_x     <= '0;
      shadow_y1    <= '0;
      shadow_y2    <= '0;
      shadow_valid <= 1'b0;
    end else begin
      vsync_prev <= vsync_in;
      if (vsync_rise) begin
        shadow_x     <= obstacle_xpos_1;
        shadow_y1    <= obstacle_ypos_1;
        shadow_y2    <= obstacle_ypos_2;
        shadow_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q      <= MODE_PLAY;
      frame_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      frame_cnt_q <= frame_cnt_d;
      blink_q     <= blink_d;
    end
  end

  always_comb begin
    mode_d      = mode_q;
    frame_cnt_d = frame_cnt_q;
    blink_d     = blink_q;
    if (vsync_rise) begin
      case (mode_q)
        MODE_PLAY: begin
          if (endgame) begin
            mode_d      = MODE_END;
            frame_cnt_d = '0;
            blink_d     = 1'b1;
          end
        end
        MODE_END: begin
          if (frame_cnt_q == BLINK_LAST) begin
            frame_cnt_d = '0;
            blink_d     = ~blink_q;
          end else begin
            frame_cnt_d = frame_cnt_q + 8'd1;
          end
        end
        default: mode_d = MODE_PLAY;
      endcase
    end
  end

  // Compare at 13 bits so a column near the top of the 12-bit range cannot wrap to x=0.
  always_comb begin
    h13    = {2'b00, hcount_in};
    v13    = {2'b00, vcount_in};
    x_lo   = {1'b0, shadow_x};
    x_hi   = x_lo + OBST_W13;
    in_x   = (h13 >= x_lo) && (h13 < x_hi);
    in_up  = v13 < {1'b0, shadow_y1};
    in_low = v13 >= {1'b0, shadow_y2};
    hit    = shadow_valid && in_x && (in_up || in_low);
  end

  always_comb begin
    obst_color = OBST_COLOR;
    if (mode_q == MODE_END && blink_q)
      obst_color = END_COLOR;
    pix_color = hit ? obst_color : rgb_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_s1 <= '0;
      vcount_s1 <= '0;
      hsync_s1  <= 1'b0;
      hblnk_s1  <= 1'b0;
      vsync_s1  <= 1'b0;
      vblnk_s1  <= 1'b0;
      rgb_s1    <= '0;
    end else begin
      hcount_s1 <= hcount_in;
      vcount_s1 <= vcount_in;
      hsync_s1  <= hsync_in;
      hblnk_s1  <= hblnk_in;
      vsync_s1  <= vsync_in;
      vblnk_s1  <= vblnk_in;
      rgb_s1    <= pix_color;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vsync_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      hcount_out <= hcount_s1;
      vcount_out <= vcount_s1;
      hsync_out  <= hsync_s1;
      hblnk_out  <= hblnk_s1;
      vsync_out  <= vsync_s1;
      vblnk_out  <= vblnk_s1;
      rgb_out    <= (hblnk_s1 || vblnk_s1) ? 12'h000 : rgb_s1;
    end
  end

endmodule

// File: tb/tb_draw_obstacle.sv
// Bench for draw_obstacle: directed vectors plus randomized pixels against a
// frame-level reference model with a two-cycle delay line.
module tb_draw_obstacle;

  localparam int          B    = 2;
  localparam int          W    = 40;
  localparam logic [11:0] OBST = 12'h0A0;
  localparam logic [11:0] ENDC = 12'hF00;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] hcount_in, vcount_in;
  logic        hsync_in, hblnk_in, vsync_in, vblnk_in;
  logic [11:0] rgb_in;
  logic [11:0] obstacle_xpos_1, obstacle_ypos_1, obstacle_ypos_2;
  logic        endgame;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, hblnk_out, vsync_out, vblnk_out;
  logic [11:0] rgb_out;

  draw_obstacle #(
    .OBST_W      (W),
    .OBST_COLOR  (OBST),
    .END_COLOR   (ENDC),
    .BLINK_FRAMES(B)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .hcount_in      (hcount_in),
    .vcount_in      (vcount_in),
    .hsync_in       (hsync_in),
    .hblnk_in       (hblnk_in),
    .vsync_in       (vsync_in),
    .vblnk_in       (vblnk_in),
    .rgb_in         (rgb_in),
    .obstacle_xpos_1(obstacle_xpos_1),
    .obstacle_ypos_1(obstacle_ypos_1),
    .obstacle_ypos_2(obstacle_ypos_2),
    .endgame        (endgame),
    .hcount_out     (hcount_out),
    .vcount_out     (vcount_out),
    .hsync_out      (hsync_out),
    .hblnk_out      (hblnk_out),
    .vsync_out      (vsync_out),
    .vblnk_out      (vblnk_out),
    .rgb_out        (rgb_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [10:0] hc;
    logic [10:0] vc;
    logic        hs, hb, vs, vb;
    logic [11:0] rgb;
  } rec_t;

  rec_t q[$];
  int   ncmp  = 0;
  int   nfail = 0;

  // Reference state: what was latched at the last vsync edge, and frames since game over.
  bit m_valid, m_end, m_prev_vs;
  int m_sx, m_sy1, m_sy2, m_frames;

  function automatic logic [11:0] model_pixel(int hc, int vc, bit hb, bit vb, logic [11:0] rgb);
    bit hit;
    logic [11:0] col;
    hit = m_valid && hc >= m_sx && hc < m_sx + W && (vc < m_sy1 || vc >= m_sy2);
    col = (m_end && ((m_frames / B) % 2 == 0)) ? ENDC : OBST;
    if (hb || vb) return 12'h000;
    return hit ? col : rgb;
  endfunction

  task automatic model_edge();
    rec_t r;
    if (rst) begin
      q.delete();
      q.push_back('0);
      q.push_back('0);
      m_valid = 0; m_end = 0; m_prev_vs = 0; m_frames = 0;
      m_sx = 0; m_sy1 = 0; m_sy2 = 0;
    end else begin
      r.hc = hcount_in; r.vc = vcount_in;
      r.hs = hsync_in;  r.hb = hblnk_in; r.vs = vsync_in; r.vb = vblnk_in;
      r.rgb = model_pixel(int'(hcount_in), int'(vcount_in), hblnk_in, vblnk_in, rgb_in);
      if (vsync_in && !m_prev_vs) begin
        m_sx = int'(obstacle_xpos_1); m_sy1 = int'(obstacle_ypos_1); m_sy2 = int'(obstacle_ypos_2);
        m_valid = 1;
        if (m_end) m_frames++;
        else if (endgame) begin m_end = 1; m_frames = 0; end
      end
      m_prev_vs = vsync_in;
      q.push_back(r);
      void'(q.pop_front());
    end
  endtask

  task automatic step(input logic r, input logic [10:0] hc, input logic [10:0] vc,
                      input logic hs, input logic hb, input logic vs, input logic vb,
                      input logic [11:0] rgb, input logic eg);
    rec_t e;
    rst = r; hcount_in = hc; vcount_in = vc; hsync_in = hs; hblnk_in = hb;
    vsync_in = vs; vblnk_in = vb; rgb_in = rgb; endgame = eg;
    @(posedge clk);
    model_edge();
    #1;
    e = q[0];
    ncmp++;
    assert (rgb_out === e.rgb) else begin
      nfail++;
      $error("FAIL model_rgb observed=%h expected=%h", rgb_out, e.rgb);
    end
    ncmp++;
    assert ({hcount_out, vcount_out, hsync_out, hblnk_out, vsync_out, vblnk_out} ===
            {e.hc, e.vc, e.hs, e.hb, e.vs, e.vb}) else begin
      nfail++;
      $error("FAIL model_timing observed=%h/%h/%b%b%b%b expected=%h/%h/%b%b%b%b",
             hcount_out, vcount_out, hsync_out, hblnk_out, vsync_out, vblnk_out,
             e.hc, e.vc, e.hs, e.hb, e.vs, e.vb);
    end
  endtask

  task automatic pix(input int hc, input int vc, input logic hb, input logic [11:0] rgb);
    step(1'b0, 11'(hc), 11'(vc), 1'b0, hb, 1'b0, 1'b0, rgb, 1'b0);
  endtask

  task automatic vsync_pulse(input logic eg);
    step(1'b0, 11'd0, 11'd770, 1'b0, 1'b1, 1'b1, 1'b1, 12'h555, eg);
    step(1'b0, 11'd0, 11'd771, 1'b0, 1'b1, 1'b0, 1'b1, 12'h555, 1'b0);
  endtask

  // Drive one pixel, then an idle one; after the second edge rgb_out carries the probed pixel.
  task automatic probe(input string tag, input int hc, input int vc, input logic hb,
                       input logic [11:0] rgb, input logic [11:0] expv);
    pix(hc, vc, hb, rgb);
    pix(0, 0, 1'b0, 12'h000);
    ncmp++;
    assert (rgb_out === expv) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, rgb_out, expv);
    end
  endtask

  task automatic set_pos(input int x, input int y1, input int y2);
    obstacle_xpos_1 = 12'(x); obstacle_ypos_1 = 12'(y1); obstacle_ypos_2 = 12'(y2);
  endtask

  task automatic random_run(input int cycles, input bit allow_end);
    int t;
    for (int i = 0; i < cycles; i++) begin
      if ($urandom_range(0, 99) == 0)
        set_pos($urandom_range(0, 1100), $urandom_range(0, 800), $urandom_range(0, 800));
      if ($urandom_range(0, 1) == 0) t = int'(obstacle_xpos_1) + $urandom_range(0, 60) - 10;
      else t = $urandom_range(0, 1100);
      if (t < 0) t = 0;
      if (t > 2047) t = 2047;
      step(($urandom_range(0, 499) == 0), 11'(t), 11'($urandom_range(0, 800)),
           1'($urandom), ($urandom_range(0, 9) == 0), ($urandom_range(0, 29) == 0),
           ($urandom_range(0, 19) == 0), 12'($urandom),
           allow_end && ($urandom_range(0, 59) == 0));
    end
  endtask

  initial begin
    set_pos(750, 250, 440);
    step(1'b1, 11'd5, 11'd5, 1'b1, 1'b1, 1'b1, 1'b1, 12'hFFF, 1'b1);
    step(1'b1, 11'd5, 11'd5, 1'b1, 1'b1, 1'b1, 1'b1, 12'hFFF, 1'b1);
    ncmp++;
    assert ({hcount_out, vcount_out, hsync_out, hblnk_out, vsync_out, vblnk_out, rgb_out} === '0) else begin
      nfail++;
      $error("FAIL reset_outputs observed=%h expected=0",
             {hcount_out, vcount_out, hsync_out, hblnk_out, vsync_out, vblnk_out, rgb_out});
    end

    probe("no_shadow", 760, 0, 1'b0, 12'h321, 12'h321);
    vsync_pulse(1'b0);
    probe("pass_through", 100, 100, 1'b0, 12'h123, 12'h123);
    probe("upper_last", 750, 249, 1'b0, 12'h111, OBST);
    probe("gap_first", 750, 250, 1'b0, 12'h222, 12'h222);
    probe("gap_last", 750, 439, 1'b0, 12'h333, 12'h333);
    probe("lower_first", 750, 440, 1'b0, 12'h444, OBST);
    probe("right_last", 789, 0, 1'b0, 12'h555, OBST);
    probe("right_past", 790, 0, 1'b0, 12'h666, 12'h666);
    probe("left_before", 749, 0, 1'b0, 12'h777, 12'h777);

    set_pos(700, 250, 440);
    probe("tear_old", 755, 0, 1'b0, 12'h888, OBST);
    probe("tear_new_early", 705, 0, 1'b0, 12'h999, 12'h999);
    vsync_pulse(1'b0);
    probe("tear_new", 705, 0, 1'b0, 12'h999, OBST);
    probe("tear_old_gone", 745, 0, 1'b0, 12'h888, 12'h888);

    set_pos(1000, 500, 300);
    vsync_pulse(1'b0);
    probe("far_first", 1000, 400, 1'b0, 12'h0AB, OBST);
    probe("far_1023", 1023, 400, 1'b0, 12'h0AB, OBST);
    probe("no_wrap", 20, 400, 1'b0, 12'h0CD, 12'h0CD);
    probe("far_past", 1040, 400, 1'b0, 12'h0EF, 12'h0EF);
    probe("blank_in_col", 1010, 0, 1'b1, 12'hABC, 12'h000);

    random_run(1500, 1'b0);

    set_pos(750, 250, 440);
    vsync_pulse(1'b0);
    for (int f = 1; f <= 6; f++) begin
      if (f > 1) vsync_pulse(1'b0);
      else vsync_pulse(1'b1);
      probe("endgame_blink", 760, 100, 1'b0, 12'h00F, (((f - 1) / 2) % 2 == 0) ? ENDC : OBST);
    end

    pix(760, 100, 1'b0, 12'h00F);
    step(1'b1, 11'd760, 11'd100, 1'b1, 1'b0, 1'b0, 1'b0, 12'h00F, 1'b0);
    ncmp++;
    assert ({hcount_out, vcount_out, hsync_out, hblnk_out, vsync_out, vblnk_out, rgb_out} === '0) else begin
      nfail++;
      $error("FAIL midframe_reset observed=%h expected=0",
             {hcount_out, vcount_out, hsync_out, hblnk_out, vsync_out, vblnk_out, rgb_out});
    end
    probe("post_reset_no_draw", 760, 100, 1'b0, 12'h246, 12'h246);
    vsync_pulse(1'b0);
    probe("post_reset_color", 760, 100, 1'b0, 12'h246, OBST);
    vsync_pulse(1'b0);
    probe("post_reset_still", 760, 100, 1'b0, 12'h246, OBST);

    random_run(2000, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/draw_obstacle.md
DRAW_OBSTACLE -- requirements
Module: draw_obstacle

Interface
REQ-001 Parameter OBST_W, default 40, obstacle column width in pixels.
REQ-002 Parameter OBST_COLOR, default 12'h0_A_0, normal obstacle colour.
REQ-003 Parameter END_COLOR, default 12'hF_0_0, endgame flash colour.
REQ-004 Parameter BLINK_FRAMES, default 30, frames per blink phase in endgame (range 1..255).
REQ-005 The block SHALL have one clock, clk, and a synchronous, active-high reset, rst, sampled on the clk rising edge.
REQ-006 clk  input  1  pixel clock.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 hcount_in, vcount_in  input  11 each  pixel position from the upstream timing stage.
REQ-009 hsync_in, hblnk_in, vsync_in, vblnk_in  input  1 each  upstream sync and blanking.
REQ-010 rgb_in  input  12  upstream pixel colour.
REQ-011 obstacle_xpos_1  input  12  left edge of the obstacle column, from the obstacle controller.
REQ-012 obstacle_ypos_1  input  12  bottom bound (exclusive) of the upper obstacle.
REQ-013 obstacle_ypos_2  input  12  top bound (inclusive) of the lower obstacle.
REQ-014 endgame  input  1  level from the obstacle controller; game over.
REQ-015 hcount_out, vcount_out  output  11 each; hsync_out, hblnk_out, vsync_out, vblnk_out  output  1 each; rgb_out  output  12.

Function
REQ-016 Frame latch: a rising edge of vsync_in (high now, low on the previous clock) SHALL copy obstacle_xpos_1, obstacle_ypos_1, obstacle_ypos_2 into shadow registers, set a shadow_valid flag, and sample endgame.
REQ-017 Rendering SHALL use only the shadow values, so positions never change mid-frame.
REQ-018 Endgame latch: once sampled high at a vsync edge it SHALL stay set until rst, regardless of later endgame values.
REQ-019 Hit test, stage 1: in_x = (hcount >= sx) and (hcount < sx + OBST_W), evaluated at 13-bit width with no wrap-around.
REQ-020 in_up = vcount < sy1; in_low = vcount >= sy2; hit = shadow_valid and in_x and (in_up or in_low).
REQ-021 If sy1 >= sy2 there is no gap and the whole column SHALL be drawn; sy1 = 0 gives no upper part; sy2 >= 768 gives no lower part.
REQ-022 Colour select, stage 2: if the stage-1 blank (hblnk or vblnk) is set, rgb_out SHALL be 12'h000; else if hit, rgb_out SHALL be the obstacle colour; else rgb_out SHALL be the delayed rgb_in.
REQ-023 Obstacle colour SHALL be OBST_COLOR when not in endgame; in endgame it SHALL be END_COLOR while blink_phase = 1 and OBST_COLOR while blink_phase = 0.
REQ-024 Blink: in endgame a frame counter SHALL increment on each vsync rising edge. On reaching BLINK_FRAMES-1 it SHALL wrap to 0 and toggle blink_phase.
REQ-025 blink_phase SHALL be set to 1 on the frame in which the endgame latch is first set.
REQ-026 Latency: every timing output and rgb_out SHALL equal the corresponding input delayed by exactly 2 clk cycles, through two register stages.
REQ-027 A vsync edge that coincides with a pixel in flight SHALL affect only pixels entering stage 1 on the following clock.

Reset
REQ-028 While rst is high, every output SHALL be 0 on the next clk edge.
REQ-029 While rst is high, both pipeline stages, the shadow registers, shadow_valid, the endgame latch, the frame counter and blink_phase SHALL be 0 on the next clk edge.
REQ-030 After rst is released, no obstacle SHALL be drawn until the first vsync rising edge; timing passthrough SHALL resume immediately.
REQ-031 Asserting rst mid-frame SHALL discard in-flight pixels and clear the endgame latch.

Verification
REQ-032 Pass-through: xpos=750, ypos1=250, ypos2=440, no endgame, pixel (100,100) with rgb_in=12'h123 -> rgb_out=12'h123 two clocks later, and timing outputs match inputs delayed by 2.
REQ-033 Geometry, same positions: (750,249) -> OBST_COLOR; (750,250) -> rgb_in; (750,439) -> rgb_in; (750,440) -> OBST_COLOR; (789,0) -> OBST_COLOR; (790,0) -> rgb_in; (749,0) -> rgb_in.
REQ-034 Tear-free update: change xpos from 750 to 700 mid-frame -> the column stays at 750 until the next vsync rising edge, then is drawn at 700.
REQ-035 Endgame: endgame pulsed high for 1 clock before a vsync edge, BLINK_FRAMES=2 -> column drawn in 12'hF00 for frames 1-2, OBST_COLOR for frames 3-4, 12'hF00 for frames 5-6; stays this way after endgame drops.
REQ-036 Edge cases: xpos=1000 (column past line end) -> hcount 1000..1023 drawn, no wrap to x=0; ypos1=500 with ypos2=300 -> full column drawn; blanking active inside the column -> rgb_out=12'h000.
REQ-037 Reset: rst asserted mid-frame during endgame -> all outputs 0 on the next clock; after release, no obstacle drawn before the first vsync edge and no endgame colour afterwards.
